test_vector_gen: RTL and testbench
==================================

# test_vector_gen

Parametrised test-vector sequencer for the GPU floating-point unit benches and built-in self-test (FP_Int2fp and sibling FP blocks). On `start` it streams DEPTH vectors of WIDTH bits over a valid/ready handshake. The pattern is selected from walking-one, walking-zero, counter or LFSR, with a seed latched at start. This replaces fixed 16x16 constant pattern ROMs. A mode-0 run with default parameters reproduces the classic 16-entry one-hot pattern.

## Interface
Parameters:
- `WIDTH`, 16, vector width in bits (>= 2)
- `DEPTH`, 16, vectors per run (>= 2)
- `POLY`, 16'hB400, Galois LFSR feedback mask (WIDTH bits), used in mode 3
- `IDX_W`, $clog2(DEPTH), index width (derived; do not override)

Ports:
- `clk`  in  1  single clock; all state on the rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `start`  in  1  begin a run; honoured only when idle
- `mode`  in  2  0 walking-one, 1 walking-zero, 2 counter, 3 LFSR; latched at start
- `seed`  in  WIDTH  counter/LFSR start value; latched at start
- `out_valid`  out  1  `dout` holds a vector
- `out_ready`  in  1  consumer accepts `dout`
- `dout`  out  WIDTH  current vector
- `idx`  out  IDX_W  index (0..DEPTH-1) of current vector
- `last`  out  1  current vector is index DEPTH-1 (qualified by `out_valid`)
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse after the final handshake

## Operation
- FSM states:
  - IDLE: `busy`=0, `out_valid`=0. `start`=1 latches `mode`/`seed`, loads vector 0, sets `idx`=0 and goes to RUN.
  - RUN: `busy`=1, `out_valid`=1. On handshake (`out_valid & out_ready`) with `idx`<DEPTH-1: `idx`++ and load the next vector. On handshake with `idx`=DEPTH-1: go to DONE.
  - DONE: lasts one cycle. `done`=1, `busy`=0, `out_valid`=0. Then IDLE.
- Vector i, per mode:
  - Mode 0 (walking-one): bit (WIDTH-1 - (i mod WIDTH)) set, all others clear. MSB first; rotate right each step; wraps to MSB when DEPTH > WIDTH.
  - Mode 1 (walking-zero): bitwise inverse of mode 0.
  - Mode 2 (counter): (seed + i) mod 2^WIDTH. Wraps silently.
  - Mode 3 (LFSR): v0 = seed, or 1 if seed == 0 (lock-up avoidance). Next = (v >> 1) ^ (v[0] ? POLY : 0).
- `seed` is ignored in modes 0/1.
- `start` during RUN or DONE is ignored; no queueing.
- `mode`/`seed` changes after start have no effect on the current run.
- `last` = (`idx` == DEPTH-1) while in RUN; 0 otherwise.

## Timing
- Reset (async assert, takes effect immediately): IDLE, `out_valid`=0, `dout`=0, `idx`=0, `last`=0, `busy`=0, `done`=0.
- Reset mid-run aborts with no `done` pulse. The first `start` after reset deassertion begins a fresh run.
- Start latency: `start` sampled high at edge k → `out_valid`=1 with vector 0 after edge k.
- Throughput: one vector per cycle while `out_ready`=1. A full run of DEPTH vectors takes DEPTH cycles, plus one DONE cycle.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `dout`, `idx` and `last` hold stable. `out_valid` never drops before its handshake.
- `dout`, `idx` and `last` are registered; no combinational path from `out_ready` to them.
- `done` is high for exactly the one cycle after the final handshake edge.
- `start` is not sampled in the DONE cycle. The earliest restart is the first IDLE cycle, two cycles after the last handshake edge.

## Test plan
- Reset defaults: assert `rst` asynchronously mid-cycle → all outputs 0 immediately. Hold `start`=0 → `busy` stays 0.
- Walking-one, defaults, `out_ready`=1: `dout` = 0x8000, 0x4000, …, 0x0001 over 16 cycles. `last` only with 0x0001. `done` pulses once the next cycle. Mode 1 gives 0x7FFF … 0xFFFE.
- Counter wrap, mode 2, seed 0xFFFE, DEPTH 16 → 0xFFFE, 0xFFFF, 0x0000, …, 0x000D.
- LFSR, mode 3: seed 0 → v0 = 0x0001, v1 = 0xB400, v2 = 0x5A00. Seed 0x0002 → v0 = 0x0002, v1 = 0x0001.
- Backpressure: toggle `out_ready` pseudo-randomly → the sequence is identical to the `out_ready`=1 run. `dout`/`idx` are stable during stalls. `start` pulses during RUN are ignored (`idx` not reset).
- Reset mid-run at `idx`=7 → outputs clear with no `done`. A new start (mode 0) restarts at `idx`=0 with `dout`=0x8000. Also WIDTH=8, DEPTH=10 mode 0: 0x80 … 0x01, 0x80, 0x40.

Source files
------------

// File: rtl/test_vector_gen.sv
// test_vector_gen: streams DEPTH test vectors (walking-one/zero, counter, LFSR)
// over a valid/ready handshake, one run per accepted start.
module test_vector_gen #(
   parameter int               WIDTH = 16,
   parameter int               DEPTH = 16,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(16'hB400),
   parameter int               IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] seed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] dout,
   output logic [IDX_W-1:0] idx,
   output logic             last,
   output logic             busy,
   output logic             done
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [WIDTH-1:0] MSB     = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [IDX_W-1:0] IDX_END = IDX_W'(DEPTH - 1);
   state_t           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [WIDTH-1:0] dout_q, dout_d, first_v, next_v;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             last_q, last_d;
   assign first_v = mode == 2'd0 ? MSB :
                    mode == 2'd1 ? ~MSB :
                    mode == 2'd2 ? seed :
                    (seed == '0 ? WIDTH'(1) : seed);
   // Walking patterns are a plain rotate-right of the previous vector, so
   // wrap-around past WIDTH entries falls out for free.
   assign next_v = !mode_q[1] ? {dout_q[0], dout_q[WIDTH-1:1]} :
                   mode_q[0]  ? ((dout_q >> 1) ^ (dout_q[0] ? POLY : '0)) :
                   dout_q + 1'b1;
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      dout_d  = dout_q;
      idx_d   = idx_q;
      last_d  = last_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = RUN;
            mode_d  = mode;
            dout_d  = first_v;
            idx_d   = '0;
            last_d  = 1'b0;
         end
         RUN: if (out_ready) begin
            if (last_q) begin
               state_d = DONE;
               last_d  = 1'b0;
            end else begin
               idx_d  = idx_q + 1'b1;
               dout_d = next_v;
               last_d = (idx_q + 1'b1) == IDX_END;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= '0;
         dout_q  <= '0;
         idx_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         dout_q  <= dout_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
      end
   end
   assign out_valid = state_q == RUN;
   assign busy      = state_q == RUN;
   assign done      = state_q == DONE;
   assign dout      = dout_q;
   assign idx       = idx_q;
   assign last      = last_q;
endmodule

// File: tb/tb_test_vector_gen.sv
// tb_test_vector_gen: directed checks of test_vector_gen at default size and
// at WIDTH=8/DEPTH=10.
module tb_test_vector_gen;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  mode = '0;
   logic [15:0] seed = '0;
   logic        out_ready = 1'b1;
   logic        out_valid, last, busy, done;
   logic [15:0] dout;
   logic [3:0]  idx;
   logic        start2 = 1'b0;
   logic        out_valid2, last2, busy2, done2;
   logic [7:0]  dout2;
   logic [3:0]  idx2;
   int          checks = 0;
   int          errors = 0;
   logic [15:0] got_v [16];
   logic [3:0]  got_i [16];
   logic        got_l [16];
   logic [15:0] ref_v [16];
   int          got_n;

   always #5 clk = ~clk;

   test_vector_gen dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
      .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .idx(idx),
      .last(last), .busy(busy), .done(done)
   );

   test_vector_gen #(.WIDTH(8), .DEPTH(10), .POLY(8'hB8)) dut8 (
      .clk(clk), .rst(rst), .start(start2), .mode(2'd0), .seed(8'h00),
      .out_valid(out_valid2), .out_ready(1'b1), .dout(dout2), .idx(idx2),
      .last(last2), .busy(busy2), .done(done2)
   );

   // Starts a run, changes mode/seed right after start, collects every
   // handshaken vector and checks stalls, the done pulse and its end.
   task automatic run_seq(input logic [1:0] m, input logic [15:0] s, input bit bp);
      logic        stalled;
      logic [15:0] sv;
      logic [3:0]  si;
      got_n = 0;
      stalled = 1'b0;
      @(negedge clk);
      mode = m; seed = s; start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0; mode = m + 2'd1; seed = ~s;
      for (int c = 0; c < 400 && got_n < 16; c++) begin
         if (bp) begin
            out_ready = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
         end
         checks++;
         if (out_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL run_valid: out_valid=%b busy=%b want 1 1", out_valid, busy);
         end
         stalled = 1'b0;
         if (out_valid && out_ready) begin
            got_v[got_n] = dout; got_i[got_n] = idx; got_l[got_n] = last;
            got_n++;
         end else begin
            stalled = 1'b1; sv = dout; si = idx;
         end
         @(negedge clk);
         if (stalled) begin
            checks++;
            if (dout !== sv || idx !== si) begin
               errors++;
               $display("FAIL stall_hold: dout=%h idx=%0d want %h %0d", dout, idx, sv, si);
            end
         end
      end
      start = 1'b0; out_ready = 1'b1;
      checks++;
      if (got_n != 16) begin
         errors++;
         $display("FAIL run_timeout: got %0d vectors want 16", got_n);
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse: done=%b busy=%b valid=%b want 1 0 0", done, busy, out_valid);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL done_end: done=%b busy=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_reset;
      checks++;
      if (dout !== 16'h0 || idx !== 4'h0 || out_valid !== 1'b0 || last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_init: dout=%h idx=%0d v=%b l=%b b=%b d=%b want all 0", dout, idx, out_valid, last, busy, done);
      end
      @(negedge clk); rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_hold: busy=%b valid=%b want 0 0", busy, out_valid);
      end
      mode = 2'd2; seed = 16'h0005; start = 1'b1;
      @(negedge clk); start = 1'b0;
      checks++;
      if (dout !== 16'h0005 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL start_latency: dout=%h valid=%b want 0005 1", dout, out_valid);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (dout !== 16'h0 || out_valid !== 1'b0 || busy !== 1'b0 || idx !== 4'h0) begin
         errors++;
         $display("FAIL async_reset: dout=%h valid=%b busy=%b idx=%0d want 0", dout, out_valid, busy, idx);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_walk_one;
      logic [15:0] e;
      run_seq(2'd0, 16'hFFFF, 1'b0);
      for (int i = 0; i < 16; i++) begin
         e = 16'h8000 >> i;
         checks++;
         if (got_v[i] !== e || got_i[i] !== 4'(i) || got_l[i] !== (i == 15)) begin
            errors++;
            $display("FAIL walk1[%0d]: dout=%h idx=%0d last=%b want %h %0d %b", i, got_v[i], got_i[i], got_l[i], e, i, i == 15);
         end
      end
   endtask

   task automatic test_walk_zero;
      logic [15:0] e;
      run_seq(2'd1, 16'h0000, 1'b0);
      for (int i = 0; i < 16; i++) begin
         e = ~(16'h8000 >> i);
         checks++;
         if (got_v[i] !== e) begin
            errors++;
            $display("FAIL walk0[%0d]: dout=%h want %h", i, got_v[i], e);
         end
      end
   endtask

   task automatic test_counter;
      logic [15:0] e;
      run_seq(2'd2, 16'hFFFE, 1'b0);
      for (int i = 0; i < 16; i++) begin
         e = 16'hFFFE + 16'(i);
         checks++;
         if (got_v[i] !== e) begin
            errors++;
            $display("FAIL counter[%0d]: dout=%h want %h", i, got_v[i], e);
         end
      end
   endtask

   task automatic test_lfsr;
      logic [15:0] e0 [3];
      e0 = '{16'h0001, 16'hB400, 16'h5A00};
      run_seq(2'd3, 16'h0000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (got_v[i] !== e0[i]) begin
            errors++;
            $display("FAIL lfsr_s0[%0d]: dout=%h want %h", i, got_v[i], e0[i]);
         end
      end
      run_seq(2'd3, 16'h0002, 1'b0);
      checks++;
      if (got_v[0] !== 16'h0002 || got_v[1] !== 16'h0001) begin
         errors++;
         $display("FAIL lfsr_s2: v0=%h v1=%h want 0002 0001", got_v[0], got_v[1]);
      end
   endtask

   task automatic test_backpressure;
      run_seq(2'd3, 16'hACE1, 1'b0);
      ref_v = got_v;
      run_seq(2'd3, 16'hACE1, 1'b1);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (got_v[i] !== ref_v[i] || got_i[i] !== 4'(i)) begin
            errors++;
            $display("FAIL bp_seq[%0d]: dout=%h idx=%0d want %h %0d", i, got_v[i], got_i[i], ref_v[i], i);
         end
      end
   endtask

   task automatic test_reset_mid_run;
      @(negedge clk);
      mode = 2'd0; start = 1'b1; out_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (7) @(negedge clk);
      checks++;
      if (idx !== 4'd7 || dout !== 16'h0100) begin
         errors++;
         $display("FAIL mid_run_idx: idx=%0d dout=%h want 7 0100", idx, dout);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (dout !== 16'h0 || idx !== 4'h0 || out_valid !== 1'b0 || last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL mid_run_reset: dout=%h idx=%0d v=%b l=%b b=%b d=%b want all 0", dout, idx, out_valid, last, busy, done);
      end
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL no_done_after_reset: done=%b busy=%b want 0 0", done, busy);
      end
      run_seq(2'd0, 16'h1234, 1'b0);
      checks++;
      if (got_v[0] !== 16'h8000 || got_i[0] !== 4'd0) begin
         errors++;
         $display("FAIL restart: dout=%h idx=%0d want 8000 0", got_v[0], got_i[0]);
      end
   endtask

   task automatic test_small;
      logic [7:0] e [10];
      e = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80, 8'h40};
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (dout2 !== e[i] || idx2 !== 4'(i) || last2 !== (i == 9) || out_valid2 !== 1'b1) begin
            errors++;
            $display("FAIL small[%0d]: dout=%h idx=%0d last=%b valid=%b want %h %0d %b 1", i, dout2, idx2, last2, out_valid2, e[i], i, i == 9);
         end
         @(negedge clk);
      end
      checks++;
      if (done2 !== 1'b1 || busy2 !== 1'b0) begin
         errors++;
         $display("FAIL small_done: done=%b busy=%b want 1 0", done2, busy2);
      end
   endtask

   initial begin
      #2;
      test_reset;
      test_walk_one;
      test_walk_zero;
      test_counter;
      test_lfsr;
      test_backpressure;
      test_reset_mid_run;
      test_small;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
